// File: rtl/alu_share_ctrl.sv
// Two-requester front end for a shared combinational ALU: arbitrates, registers
// operands for one execute cycle, and holds the captured result behind a valid/ready port.
module alu_share_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter bit          RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [2:0]       r0_op,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [2:0]       r1_op,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_gin,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_zout,
  input  logic             alu_nout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_zout,
  output logic             rsp_nout,
  output logic             rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]       alu_gin_q, alu_gin_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             z_q, z_d, n_q, n_d, err_q, err_d;

  logic win;
  logic accept;
  logic illegal;

  always_comb begin
    win = 1'b0;
    if (r0_valid && r1_valid) win = RR_EN ? ~last_q : 1'b0;
    else if (r1_valid)        win = 1'b1;
  end

  // Grant is gated by reset so no handshake can be reported for an op that is dropped.
  assign accept   = !reset && (r0_valid || r1_valid) &&
                    ((state_q == IDLE) || (state_q == RESP && rsp_ready));
  assign r0_ready = accept && !win;
  assign r1_ready = accept && win;
  assign illegal  = (alu_gin_q == 3'b011) || (alu_gin_q == 3'b101);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_gin_d = alu_gin_q;
    id_d      = id_q;
    sum_d     = sum_q;
    z_d       = z_q;
    n_d       = n_q;
    err_d     = err_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      last_d    = win;
      id_d      = win;
      alu_a_d   = win ? r1_a  : r0_a;
      alu_b_d   = win ? r1_b  : r0_b;
      alu_gin_d = win ? r1_op : r0_op;
    end
    if (state_q == EXEC) begin
      sum_d = illegal ? '0   : alu_sum;
      z_d   = illegal ? 1'b0 : alu_zout;
      n_d   = illegal ? 1'b0 : alu_nout;
      err_d = illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_gin_q <= 3'b010;
      id_q      <= 1'b0;
      sum_q     <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_gin_q <= alu_gin_d;
      id_q      <= id_d;
      sum_q     <= sum_d;
      z_q       <= z_d;
      n_q       <= n_d;
      err_q     <= err_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_gin   = alu_gin_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_zout  = z_q;
  assign rsp_nout  = n_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench: round-robin DUT plus a fixed-priority DUT sharing the same stimulus,
// each attached to its own behavioural ALU.
module tb_alu_share_ctrl;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         r0_valid, r1_valid, rsp_ready;
  logic [2:0]   r0_op, r1_op;
  logic [W-1:0] r0_a, r0_b, r1_a, r1_b;

  logic         rr_r0_ready, rr_r1_ready, rr_rsp_valid, rr_rsp_id, rr_z, rr_n, rr_err;
  logic [W-1:0] rr_alu_a, rr_alu_b, rr_rsp_sum;
  logic [2:0]   rr_gin;
  logic [W+1:0] rr_alu;

  logic         fp_r0_ready, fp_r1_ready, fp_rsp_valid, fp_rsp_id, fp_z, fp_n, fp_err;
  logic [W-1:0] fp_alu_a, fp_alu_b, fp_rsp_sum;
  logic [2:0]   fp_gin;
  logic [W+1:0] fp_alu;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Returns {n, z, sum}; illegal codes yield garbage that must never be captured.
  function automatic logic [W+1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] s;
    case (op)
      3'b000:  s = a & b;
      3'b001:  s = a | b;
      3'b010:  s = a + b;
      3'b110:  s = a - b;
      3'b111:  s = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b100:  s = b << a[4:0];
      default: s = 32'hDEADBEEF;
    endcase
    return {s[W-1], (s == '0), s};
  endfunction

  assign rr_alu = alu_f(rr_gin, rr_alu_a, rr_alu_b);
  assign fp_alu = alu_f(fp_gin, fp_alu_a, fp_alu_b);

  alu_share_ctrl #(.WIDTH(W), .RR_EN(1'b1)) u_rr (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(rr_r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(rr_r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_gin(rr_gin),
    .alu_sum(rr_alu[W-1:0]), .alu_zout(rr_alu[W]), .alu_nout(rr_alu[W+1]),
    .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rr_rsp_id),
    .rsp_sum(rr_rsp_sum), .rsp_zout(rr_z), .rsp_nout(rr_n), .rsp_err(rr_err)
  );

  alu_share_ctrl #(.WIDTH(W), .RR_EN(1'b0)) u_fp (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(fp_r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(fp_r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_gin(fp_gin),
    .alu_sum(fp_alu[W-1:0]), .alu_zout(fp_alu[W]), .alu_nout(fp_alu[W+1]),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
    .rsp_sum(fp_rsp_sum), .rsp_zout(fp_z), .rsp_nout(fp_n), .rsp_err(fp_err)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_r0(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    r0_valid = v; r0_op = op; r0_a = a; r0_b = b;
  endtask

  task automatic set_r1(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    r1_valid = v; r1_op = op; r1_a = a; r1_b = b;
  endtask

  initial begin
    rsp_ready = 1'b0;
    set_r0(1'b0, 3'b000, '0, '0);
    set_r1(1'b0, 3'b000, '0, '0);

    // Reset state
    do_reset();
    #1;
    chk("rst_r0_ready", rr_r0_ready, 0);
    chk("rst_r1_ready", rr_r1_ready, 0);
    chk("rst_rsp_valid", rr_rsp_valid, 0);
    chk("rst_alu_a", rr_alu_a, 0);
    chk("rst_alu_b", rr_alu_b, 0);
    chk("rst_alu_gin", rr_gin, 3'b010);
    chk("rst_rsp_sum", rr_rsp_sum, 0);
    chk("rst_rsp_err", rr_err, 0);

    // 1: single ADD 5+7
    set_r0(1'b1, 3'b010, 5, 7);
    rsp_ready = 1'b1;
    #1;
    chk("t1_r0_ready", rr_r0_ready, 1);
    chk("t1_r1_ready", rr_r1_ready, 0);
    tick();
    set_r0(1'b0, 3'b110, 99, 99);
    #1;
    chk("t1_exec_rsp_valid", rr_rsp_valid, 0);
    chk("t1_exec_alu_a", rr_alu_a, 5);
    chk("t1_exec_alu_b", rr_alu_b, 7);
    chk("t1_exec_gin", rr_gin, 3'b010);
    tick();
    chk("t1_rsp_valid", rr_rsp_valid, 1);
    chk("t1_sum", rr_rsp_sum, 12);
    chk("t1_z", rr_z, 0);
    chk("t1_n", rr_n, 0);
    chk("t1_id", rr_rsp_id, 0);
    tick();
    chk("t1_back_idle", rr_rsp_valid, 0);

    // 2: round-robin contention, SUB 3-3 vs SLT 2<9
    do_reset();
    set_r0(1'b1, 3'b110, 3, 3);
    set_r1(1'b1, 3'b111, 2, 9);
    rsp_ready = 1'b1;
    #1;
    chk("t2_g0_r0", rr_r0_ready, 1);
    chk("t2_g0_r1", rr_r1_ready, 0);
    tick();
    chk("t2_exec_r0", rr_r0_ready, 0);
    chk("t2_exec_r1", rr_r1_ready, 0);
    tick();
    chk("t2_rsp0_valid", rr_rsp_valid, 1);
    chk("t2_rsp0_sum", rr_rsp_sum, 0);
    chk("t2_rsp0_z", rr_z, 1);
    chk("t2_rsp0_id", rr_rsp_id, 0);
    chk("t2_g1_r0", rr_r0_ready, 0);
    chk("t2_g1_r1", rr_r1_ready, 1);
    tick();
    chk("t2_exec2_valid", rr_rsp_valid, 0);
    tick();
    chk("t2_rsp1_sum", rr_rsp_sum, 1);
    chk("t2_rsp1_z", rr_z, 0);
    chk("t2_rsp1_id", rr_rsp_id, 1);
    chk("t2_g2_r0", rr_r0_ready, 1);
    chk("t2_g2_r1", rr_r1_ready, 0);
    tick();
    tick();
    chk("t2_rsp2_id", rr_rsp_id, 0);

    // 3: fixed priority, both valid for 4 ops
    do_reset();
    set_r0(1'b1, 3'b010, 1, 2);
    set_r1(1'b1, 3'b010, 3, 4);
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t3_fp_r0_ready", fp_r0_ready, (i % 2 == 0) ? 1 : 0);
      chk("t3_fp_r1_ready", fp_r1_ready, 0);
      if (i % 2 == 0 && i > 0) chk("t3_fp_rsp_id", fp_rsp_id, 0);
      tick();
    end

    // 4: backpressure, then same-cycle re-accept
    do_reset();
    set_r0(1'b1, 3'b010, 10, 20);
    set_r1(1'b0, 3'b001, 32'hF0, 32'h0F);
    rsp_ready = 1'b0;
    tick();
    set_r0(1'b0, 3'b000, 0, 0);
    tick();
    r1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_hold_valid", rr_rsp_valid, 1);
      chk("t4_hold_sum", rr_rsp_sum, 30);
      chk("t4_hold_id", rr_rsp_id, 0);
      chk("t4_hold_r1_ready", rr_r1_ready, 0);
      chk("t4_hold_alu_a", rr_alu_a, 10);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t4_reaccept_r1", rr_r1_ready, 1);
    chk("t4_reaccept_r0", rr_r0_ready, 0);
    tick();
    r1_valid = 1'b0;
    chk("t4_valid_drop", rr_rsp_valid, 0);
    tick();
    chk("t4_rsp2_valid", rr_rsp_valid, 1);
    chk("t4_rsp2_sum", rr_rsp_sum, 32'hFF);
    chk("t4_rsp2_id", rr_rsp_id, 1);

    // 5: illegal op then legal op
    do_reset();
    set_r0(1'b1, 3'b011, 1, 2);
    rsp_ready = 1'b1;
    tick();
    set_r0(1'b1, 3'b110, 2, 5);
    tick();
    chk("t5_err", rr_err, 1);
    chk("t5_sum", rr_rsp_sum, 0);
    chk("t5_z", rr_z, 0);
    chk("t5_n", rr_n, 0);
    chk("t5_next_accept", rr_r0_ready, 1);
    tick();
    set_r0(1'b0, 3'b000, 0, 0);
    tick();
    chk("t5_legal_err", rr_err, 0);
    chk("t5_legal_sum", rr_rsp_sum, 32'hFFFFFFFD);
    chk("t5_legal_n", rr_n, 1);

    // 6: reset during EXEC
    do_reset();
    set_r0(1'b1, 3'b010, 4, 4);
    set_r1(1'b0, 3'b010, 6, 6);
    rsp_ready = 1'b1;
    tick();
    reset = 1'b1;
    set_r0(1'b1, 3'b110, 9, 4);
    r1_valid = 1'b1;
    #1;
    chk("t6_rst_r0_ready", rr_r0_ready, 0);
    chk("t6_rst_r1_ready", rr_r1_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_rsp_valid", rr_rsp_valid, 0);
    chk("t6_alu_gin", rr_gin, 3'b010);
    chk("t6_alu_a", rr_alu_a, 0);
    chk("t6_rsp_sum", rr_rsp_sum, 0);
    chk("t6_first_r0", rr_r0_ready, 1);
    chk("t6_first_r1", rr_r1_ready, 0);
    tick();
    chk("t6_no_stale_rsp", rr_rsp_valid, 0);
    set_r0(1'b0, 3'b000, 0, 0);
    r1_valid = 1'b0;
    tick();
    chk("t6_rsp_sum_new", rr_rsp_sum, 5);
    chk("t6_rsp_id_new", rr_rsp_id, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
